irq_ctrl_16: RTL

- 16-source interrupt controller for the 19-bit CPU.
- Captures request edges into a pending register and applies a CPU-written mask.
- Selects the winning source through a one-hot/priority 16-to-4 encoder and runs an irq/ack/eoi handshake with the CPU sequencer.
- Sits between peripheral request lines and the control unit; supplies the 4-bit vector used to index the handler table.

---
 rtl/irq_pkg.sv | 22 ++
 rtl/prio_enc_16x4.sv | 21 ++
 rtl/irq_ctrl_16.sv | 116 +++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the 16-source interrupt controller and its encoder.
package irq_pkg;

  localparam int unsigned NUM_SRC = 16;
  localparam int unsigned VEC_W   = 4;
  localparam logic [NUM_SRC-1:0] MASK_RST = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } irq_state_e;

  // One-hot decode of a vector, used to build the per-source clear.
  function automatic logic [NUM_SRC-1:0] vec_onehot(input logic [VEC_W-1:0] v);
    logic [NUM_SRC-1:0] oh;
    oh    = '0;
    oh[v] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/prio_enc_16x4.sv
// 16-to-4 priority encoder: the lowest set bit of eligible wins.
module prio_enc_16x4
  import irq_pkg::*;
(
  input  logic [NUM_SRC-1:0] eligible,
  output logic [VEC_W-1:0]   idx,
  output logic               any
);

  // Scan from the top down so the lowest index is written last and wins.
  always_comb begin
    idx = '0;
    any = |eligible;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        idx = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_16.sv
// 16-source interrupt controller: edge/level capture, mask, priority select
// and irq/ack/eoi handshake with the CPU sequencer.
module irq_ctrl_16
  import irq_pkg::*;
#(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_din,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               irq,
  output logic [VEC_W-1:0]   vec,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pend,
  output logic [NUM_SRC-1:0] mask
);

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] req_q;
  logic [NUM_SRC-1:0] set_c;
  logic [NUM_SRC-1:0] clr_c;
  logic [NUM_SRC-1:0] eligible_c;
  logic [VEC_W-1:0]   win_idx_c;
  logic               win_any_c;
  logic               irq_d;
  logic [VEC_W-1:0]   vec_d;
  logic               in_service_d;

  // Request capture source: rising edge or raw level.
  always_comb begin
    if (EDGE_MODE) begin
      set_c = req & ~req_q;
    end else begin
      set_c = req;
    end
  end

  assign eligible_c = pend & ~mask;

  prio_enc_16x4 u_prio_enc (
    .eligible (eligible_c),
    .idx      (win_idx_c),
    .any      (win_any_c)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    irq_d        = irq;
    vec_d        = vec;
    in_service_d = in_service;
    clr_c        = '0;
    case (state_q)
      IDLE: begin
        irq_d = 1'b0;
        if (win_any_c) begin
          state_d = REQ;
          irq_d   = 1'b1;
          vec_d   = win_idx_c;
        end
      end
      REQ: begin
        // Ack takes precedence over both eoi and a masking write.
        if (irq_ack) begin
          state_d      = SERVICE;
          irq_d        = 1'b0;
          in_service_d = 1'b1;
          clr_c        = vec_onehot(vec);
        end else if (mask_we && mask_din[vec]) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      SERVICE: begin
        irq_d = 1'b0;
        if (eoi) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        irq_d        = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  // State, capture and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      pend       <= '0;
      mask       <= MASK_RST;
      irq        <= 1'b0;
      vec        <= '0;
      in_service <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req;
      pend       <= set_c | (pend & ~clr_c);
      irq        <= irq_d;
      vec        <= vec_d;
      in_service <= in_service_d;
      if (mask_we) begin
        mask <= mask_din;
      end
    end
  end

endmodule
